ps2_rx_ctrl: RTL and testbench
==============================

PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 SHALL have parameter FILTER, default 8: consecutive equal synchronized samples of ps2c required before the filtered clock changes (range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 200000: clk cycles allowed between filtered ps2c falling edges inside a frame (range 16..2^20).
REQ-003 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port ps2c  in  1  raw PS/2 clock pin, asynchronous.
REQ-006 SHALL have port ps2d  in  1  raw PS/2 data pin, asynchronous.
REQ-007 SHALL have port clk_inhibit  out  1  1 = drive the ps2c pad low (open-drain host inhibit).
REQ-008 SHALL have port rx_data  out  8  received byte; valid while rx_valid=1.
REQ-009 SHALL have port rx_valid  out  1  output buffer holds a byte.
REQ-010 SHALL have port rx_ready  in  1  consumer accepts rx_data when rx_valid=1.
REQ-011 SHALL have port parity_err  out  1  one-cycle pulse: frame dropped on odd-parity failure.
REQ-012 SHALL have port frame_err  out  1  one-cycle pulse: bad start or stop bit.
REQ-013 SHALL have port timeout_err  out  1  one-cycle pulse: frame aborted on timeout.
REQ-014 SHALL have port overrun  out  1  one-cycle pulse: good frame dropped because the buffer was full.
REQ-015 SHALL have port busy  out  1  FSM not in IDLE.

Function
REQ-016 SHALL synchronize ps2c and ps2d through 2 flops each before any use.
REQ-017 SHALL update filtered clock ps2c_f to the synchronized ps2c only after FILTER consecutive equal samples; shorter pulses are ignored.
REQ-018 SHALL generate a one-cycle fall pulse when ps2c_f goes 1->0; ps2d is sampled (synchronized value) in that same cycle.
REQ-019 SHALL implement FSM states IDLE, DATA, PARITY, STOP; transitions occur only on fall pulses, timeout or reset.
REQ-020 IDLE: on fall with ps2d=0 go to DATA and clear the bit counter; with ps2d=1 pulse frame_err and stay in IDLE.
REQ-021 DATA: on each fall shift ps2d in LSB first; after the 8th bit (counter 7) go to PARITY.
REQ-022 PARITY: on fall store the parity bit and go to STOP.
REQ-023 STOP: on fall always return to IDLE, with precedence stop=0 -> frame_err; else even count of ones over data+parity -> parity_err; else good frame.
REQ-024 A good frame SHALL load the buffer, with rx_valid=1 and rx_data=byte on the cycle after the stop fall pulse, if the buffer is empty or is being accepted (rx_valid&rx_ready) in the stop-fall cycle.
REQ-025 A good frame arriving with the buffer full and not accepted in that cycle SHALL be dropped with an overrun pulse; rx_data is unchanged.
REQ-026 rx_data SHALL stay stable while rx_valid=1; rx_valid clears on the cycle after rx_valid&rx_ready unless a simultaneous load per REQ-024 occurs.
REQ-027 The timeout counter SHALL clear on every fall pulse and increment in non-IDLE states.
REQ-028 When the timeout counter reaches TIMEOUT-1 the block SHALL pulse timeout_err, discard the partial frame and enter IDLE.
REQ-029 clk_inhibit SHALL be 1 only when rx_valid=1 and FSM=IDLE; it is never raised mid-frame and drops the cycle after the buffer empties.
REQ-030 At most one error/overrun pulse SHALL be asserted in any cycle.

Reset
REQ-031 With reset=0 at a clk edge: FSM=IDLE; counters=0; synchronizers and ps2c_f=1; rx_valid, rx_data, clk_inhibit, all pulses and busy=0.
REQ-032 Reset mid-frame SHALL discard the partial frame with no error pulse; the first fall after release is treated as a start bit.

Verification
REQ-033 Frame 0x1C, parity 0, stop 1, rx_ready=1 -> rx_valid for exactly 1 cycle with rx_data=0x1C, no error pulses.
REQ-034 Frame 0xA5 with parity bit 0 -> single parity_err pulse; rx_valid stays 0.
REQ-035 Frame 0x3C, correct parity, stop bit 0 -> single frame_err; rx_valid stays 0.
REQ-036 ps2c held high after 5 data bits for TIMEOUT cycles -> timeout_err pulse, busy=0; next frame 0x55 is received correctly.
REQ-037 rx_ready=0, frame 0x12 -> rx_valid=1, clk_inhibit=1; a forced second good frame 0x34 -> overrun pulse, rx_data=0x12; rx_ready=1 -> clk_inhibit=0 one cycle later.
REQ-038 A 3-cycle low glitch on ps2c (FILTER=8) is ignored with no state change; reset=0 after 4 data bits -> all outputs 0, next frame 0x1C received clean.

Source files
------------

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: pin synchronisation, clock glitch filter, frame FSM,
// one-entry output buffer with host clock inhibit while the buffer is occupied.
module ps2_rx_ctrl #(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       clk_inhibit,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned FW = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          ps2c_f;
  logic          fall;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;

  logic [1:0]    state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par, par_nxt;

  logic          to_hit_c;
  logic          good_c;
  logic          load_c;
  logic          parity_err_nxt, frame_err_nxt, timeout_nxt, overrun_nxt;
  logic          rx_valid_nxt;
  logic          filt_flip_c;

  assign to_hit_c    = (state != IDLE) && (to_cnt == TW'(TIMEOUT - 1));
  assign filt_flip_c = (c_s2 != ps2c_f) && (filt_cnt == FW'(FILTER - 1));

  // Frame decode; every transition is gated by a filtered falling edge or the timeout.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    par_nxt        = par;
    parity_err_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    timeout_nxt    = 1'b0;
    good_c         = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!d_s2) begin
            state_nxt   = DATA;
            bit_cnt_nxt = 3'd0;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end
        DATA: begin
          shreg_nxt   = {d_s2, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = d_s2;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (!d_s2)                 frame_err_nxt  = 1'b1;
          else if (!(^{shreg, par})) parity_err_nxt = 1'b1;
          else                       good_c         = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (to_hit_c) begin
      state_nxt   = IDLE;
      timeout_nxt = 1'b1;
    end
  end

  // Single-entry buffer: a good frame may load while the current byte is being taken.
  always_comb begin
    load_c       = good_c && (!rx_valid || rx_ready);
    overrun_nxt  = good_c && rx_valid && !rx_ready;
    rx_valid_nxt = rx_valid;
    if (load_c)                    rx_valid_nxt = 1'b1;
    else if (rx_valid && rx_ready) rx_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      c_s1        <= 1'b1;
      c_s2        <= 1'b1;
      d_s1        <= 1'b1;
      d_s2        <= 1'b1;
      ps2c_f      <= 1'b1;
      fall        <= 1'b0;
      filt_cnt    <= '0;
      to_cnt      <= '0;
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      clk_inhibit <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;

      // Filtered clock follows the pin only after FILTER consecutive differing samples.
      if (c_s2 == ps2c_f) begin
        filt_cnt <= '0;
      end else if (filt_flip_c) begin
        ps2c_f   <= c_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
      fall <= filt_flip_c && !c_s2;

      if (fall || state == IDLE || to_hit_c) to_cnt <= '0;
      else                                   to_cnt <= to_cnt + TW'(1);

      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;

      if (load_c) rx_data <= shreg;
      rx_valid    <= rx_valid_nxt;
      clk_inhibit <= rx_valid_nxt && (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);

      parity_err  <= parity_err_nxt;
      frame_err   <= frame_err_nxt;
      timeout_err <= timeout_nxt;
      overrun     <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: good, parity, framing, timeout, overrun, glitch and reset cases.
module tb_ps2_rx_ctrl;

  localparam int unsigned FILTER  = 8;
  localparam int unsigned TIMEOUT = 100;
  localparam int          HALF    = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       clk_inhibit;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic       overrun;
  logic       busy;

  int passed = 0;
  int total  = 0;

  int n_par = 0, n_frm = 0, n_to = 0, n_ovr = 0, n_valid = 0, n_multi = 0;
  logic [7:0] last_rx = 8'h00;

  ps2_rx_ctrl #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .clk_inhibit(clk_inhibit), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .timeout_err(timeout_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse and delivery tally, sampled mid-cycle.
  always @(negedge clk) begin
    if (parity_err)  n_par++;
    if (frame_err)   n_frm++;
    if (timeout_err) n_to++;
    if (overrun)     n_ovr++;
    if (rx_valid) begin
      n_valid++;
      last_rx = rx_data;
    end
    if ($countones({parity_err, frame_err, timeout_err, overrun}) > 1) n_multi++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2d = b;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par_ok ? ~^b : ^b);
    send_bit(stop);
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ({rx_valid, rx_data} !== 9'h000) $display("FAIL reset_rx: got %0h want 0", {rx_valid, rx_data}); else passed++;
    total++; if ({clk_inhibit, busy} !== 2'b00) $display("FAIL reset_ctl: got %b want 00", {clk_inhibit, busy}); else passed++;
    total++; if ({parity_err, frame_err, timeout_err, overrun} !== 4'b0000)
      $display("FAIL reset_pulses: got %b want 0000", {parity_err, frame_err, timeout_err, overrun}); else passed++;
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int v0 = n_valid, p0 = n_par, f0 = n_frm, t0 = n_to, o0 = n_ovr;
    send_frame(8'h1C, 1'b1, 1'b1);
    total++; if (n_valid - v0 !== 1) $display("FAIL good_valid_cycles: got %0d want 1", n_valid - v0); else passed++;
    total++; if (last_rx !== 8'h1C) $display("FAIL good_data: got %0h want 1c", last_rx); else passed++;
    total++; if ((n_par - p0) + (n_frm - f0) + (n_to - t0) + (n_ovr - o0) !== 0)
      $display("FAIL good_no_err: got %0d want 0", (n_par - p0) + (n_frm - f0) + (n_to - t0) + (n_ovr - o0)); else passed++;
  endtask

  task automatic test_parity_err();
    int v0 = n_valid, p0 = n_par, f0 = n_frm;
    send_frame(8'hA5, 1'b0, 1'b1);
    total++; if (n_par - p0 !== 1) $display("FAIL parity_pulse: got %0d want 1", n_par - p0); else passed++;
    total++; if (n_valid - v0 !== 0) $display("FAIL parity_no_valid: got %0d want 0", n_valid - v0); else passed++;
    total++; if (n_frm - f0 !== 0) $display("FAIL parity_no_frame: got %0d want 0", n_frm - f0); else passed++;
  endtask

  task automatic test_frame_err();
    int v0 = n_valid, p0 = n_par, f0 = n_frm;
    send_frame(8'h3C, 1'b1, 1'b0);
    total++; if (n_frm - f0 !== 1) $display("FAIL stop_frame_pulse: got %0d want 1", n_frm - f0); else passed++;
    total++; if (n_valid - v0 !== 0) $display("FAIL stop_no_valid: got %0d want 0", n_valid - v0); else passed++;
    total++; if (n_par - p0 !== 0) $display("FAIL stop_no_parity: got %0d want 0", n_par - p0); else passed++;
  endtask

  task automatic test_timeout();
    int t0 = n_to, v0, k = 0;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    total++; if (busy !== 1'b1) $display("FAIL timeout_busy_before: got %b want 1", busy); else passed++;
    while (n_to == t0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    total++; if (n_to - t0 !== 1) $display("FAIL timeout_pulse: got %0d want 1", n_to - t0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL timeout_busy_after: got %b want 0", busy); else passed++;
    repeat (10) @(negedge clk);
    v0 = n_valid;
    send_frame(8'h55, 1'b1, 1'b1);
    total++; if (last_rx !== 8'h55 || n_valid - v0 !== 1)
      $display("FAIL timeout_recover: got %0h/%0d want 55/1", last_rx, n_valid - v0); else passed++;
  endtask

  task automatic test_overrun();
    int o0 = n_ovr;
    @(negedge clk);
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1, 1'b1);
    total++; if ({rx_valid, clk_inhibit} !== 2'b11) $display("FAIL ovr_hold: got %b want 11", {rx_valid, clk_inhibit}); else passed++;
    total++; if (rx_data !== 8'h12) $display("FAIL ovr_data1: got %0h want 12", rx_data); else passed++;
    send_frame(8'h34, 1'b1, 1'b1);
    total++; if (n_ovr - o0 !== 1) $display("FAIL ovr_pulse: got %0d want 1", n_ovr - o0); else passed++;
    total++; if (rx_data !== 8'h12) $display("FAIL ovr_data_kept: got %0h want 12", rx_data); else passed++;
    total++; if (clk_inhibit !== 1'b1) $display("FAIL ovr_inhibit_idle: got %b want 1", clk_inhibit); else passed++;
    rx_ready = 1'b1;
    @(negedge clk);
    total++; if ({rx_valid, clk_inhibit} !== 2'b00) $display("FAIL ovr_release: got %b want 00", {rx_valid, clk_inhibit}); else passed++;
  endtask

  task automatic test_glitch();
    int f0 = n_frm, v0 = n_valid;
    @(negedge clk);
    ps2d = 1'b1;
    ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (n_frm - f0 !== 0) $display("FAIL glitch_no_edge: got %0d want 0", n_frm - f0); else passed++;
    total++; if ({busy, n_valid - v0 != 0} !== 2'b00) $display("FAIL glitch_idle: got busy=%b", busy); else passed++;
  endtask

  task automatic test_reset_midframe();
    int p0 = n_par, f0 = n_frm, t0 = n_to, o0 = n_ovr, v0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    total++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({busy, rx_valid, clk_inhibit, rx_data} !== 11'h000)
      $display("FAIL midrst_outputs: got %0h want 0", {busy, rx_valid, clk_inhibit, rx_data}); else passed++;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ((n_par - p0) + (n_frm - f0) + (n_to - t0) + (n_ovr - o0) !== 0)
      $display("FAIL midrst_no_err: got %0d want 0", (n_par - p0) + (n_frm - f0) + (n_to - t0) + (n_ovr - o0)); else passed++;
    v0 = n_valid;
    send_frame(8'h1C, 1'b1, 1'b1);
    total++; if (last_rx !== 8'h1C || n_valid - v0 !== 1)
      $display("FAIL midrst_recover: got %0h/%0d want 1c/1", last_rx, n_valid - v0); else passed++;
    total++; if ((n_par - p0) + (n_frm - f0) + (n_to - t0) + (n_ovr - o0) !== 0)
      $display("FAIL midrst_clean: got %0d want 0", (n_par - p0) + (n_frm - f0) + (n_to - t0) + (n_ovr - o0)); else passed++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    total++; if (n_multi !== 0) $display("FAIL exclusive_pulses: got %0d want 0", n_multi); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
